// File: rtl/blake2b_pkg.sv
// BLAKE2b shared constants: IV, parameter-block word and widths.
// Used by the message scheduler and the compression engine.
package blake2b_pkg;

    localparam int WORD_W      = 64;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;
    localparam int H_W         = 8 * WORD_W;
    localparam int T_W         = 128;

    localparam logic [63:0] PARAM_CONST = 64'h0000_0000_0101_0000;

    localparam logic [H_W-1:0] IV = {
        64'h5be0cd19137e2179,
        64'h1f83d9abfb41bd6b,
        64'h9b05688c2b3e6c1f,
        64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1,
        64'h3c6ef372fe94f82b,
        64'hbb67ae8584caa73b,
        64'h6a09e667f3bcc908
    };

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMP,
        DONE
    } state_t;

    // Unkeyed parameter block: only digest length varies.
    function automatic logic [H_W-1:0] h_init(input logic [7:0] nn);
        logic [H_W-1:0] h;
        h = IV;
        h[63:0] = IV[63:0] ^ PARAM_CONST ^ {56'b0, nn};
        return h;
    endfunction

endpackage

// File: rtl/blake2b_block_buf.sv
// 16x64 message block buffer with byte-masked word writes.
// Words are written in order; clear zeroes the block and the index.
module blake2b_block_buf
    import blake2b_pkg::*;
(
    input  logic               clk,
    input  logic               nreset,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [3:0]         wr_bytes,
    output logic [3:0]         idx,
    output logic [BLOCK_W-1:0] m
);

    logic [WORD_W-1:0] masked;

    always_comb begin
        masked = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < int'(wr_bytes)) begin
                masked[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset || clr) begin
            m   <= '0;
            idx <= '0;
        end else if (wr_en) begin
            m[{idx, 6'b0} +: WORD_W] <= masked;
            idx <= idx + 4'd1;
        end
    end

endmodule

// File: rtl/blake2b_msg_sched.sv
// BLAKE2b message packer and chaining controller.
// Builds 128-byte blocks, starts the engine, keeps h and t.
module blake2b_msg_sched
    import blake2b_pkg::*;
#(
    parameter int W  = 64,
    parameter int NN = 64
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             data_valid_i,
    input  logic [W-1:0]     data_i,
    input  logic             data_last_i,
    input  logic [3:0]       data_bytes_i,
    output logic             data_ready_o,
    output logic             cmp_valid_o,
    output logic [H_W-1:0]   cmp_h_o,
    output logic [BLOCK_W-1:0] cmp_m_o,
    output logic [T_W-1:0]   cmp_t_o,
    output logic             cmp_f_o,
    input  logic [H_W-1:0]   cmp_h_i,
    input  logic             cmp_valid_i,
    output logic             digest_valid_o,
    output logic [H_W-1:0]   digest_o,
    input  logic             digest_ready_i
);

    localparam logic [H_W-1:0] H0 = h_init(8'(NN));

    state_t state_q, state_d;

    logic [H_W-1:0] h_q;
    logic [T_W-1:0] t_q;
    logic           f_q;
    logic           start_q;
    logic           accept;
    logic           blk_end;
    logic           cmp_done;
    logic           buf_clr;
    logic [3:0]     eff_bytes;
    logic [3:0]     idx;
    logic [BLOCK_W-1:0] m;

    assign accept = data_valid_i & data_ready_o;

    // Non-last words always carry 8 bytes; oversize counts clamp.
    assign eff_bytes = !data_last_i ? 4'd8
                     : (data_bytes_i > 4'd8) ? 4'd8
                     : data_bytes_i;

    assign blk_end  = data_last_i | (idx == 4'(BLOCK_WORDS - 1));
    assign cmp_done = (state_q == COMP) & cmp_valid_i & ~start_q;

    blake2b_block_buf u_buf (
        .clk      (clk),
        .nreset   (nreset),
        .clr      (buf_clr),
        .wr_en    (accept),
        .wr_data  (data_i),
        .wr_bytes (eff_bytes),
        .idx      (idx),
        .m        (m)
    );

    always_comb begin
        state_d      = state_q;
        buf_clr      = 1'b0;
        data_ready_o = 1'b0;
        unique case (state_q)
            IDLE, FILL: begin
                data_ready_o = 1'b1;
                if (accept) begin
                    state_d = blk_end ? COMP : FILL;
                end
            end
            COMP: begin
                if (cmp_done) begin
                    state_d = f_q ? DONE : FILL;
                    buf_clr = ~f_q;
                end
            end
            DONE: begin
                if (digest_ready_i) begin
                    state_d = IDLE;
                    buf_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            h_q     <= H0;
            t_q     <= '0;
            f_q     <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= (state_q != COMP) && (state_d == COMP);
            if (accept) begin
                t_q <= t_q + T_W'(eff_bytes);
                if (blk_end) begin
                    f_q <= data_last_i;
                end
            end
            if (cmp_done) begin
                h_q <= cmp_h_i;
            end
            if (state_q == DONE && digest_ready_i) begin
                h_q <= H0;
                t_q <= '0;
                f_q <= 1'b0;
            end
        end
    end

    always_comb begin
        digest_o = '0;
        for (int b = 0; b < 64; b++) begin
            if (b < NN) begin
                digest_o[8*b +: 8] = h_q[8*b +: 8];
            end
        end
    end

    assign cmp_valid_o    = start_q;
    assign cmp_h_o        = h_q;
    assign cmp_m_o        = m;
    assign cmp_t_o        = t_q;
    assign cmp_f_o        = f_q;
    assign digest_valid_o = (state_q == DONE);

endmodule

// File: tb/tb_blake2b_msg_sched.sv
// Bench for blake2b_msg_sched with a behavioural BLAKE2b engine.
// Expected blocks are queued at drive time and popped on each start pulse.
module tb_blake2b_msg_sched;

    localparam int NN = 64;

    localparam logic [511:0] BIV = {
        64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
        64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
        64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
    };
    localparam logic [511:0] BINIT =
        BIV ^ {448'b0, 64'h01010000 ^ 64'(NN)};

    typedef struct {
        logic [127:0]  t;
        logic          f;
        logic [1023:0] m;
    } blk_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          data_valid_i;
    logic [63:0]   data_i;
    logic          data_last_i;
    logic [3:0]    data_bytes_i;
    logic          data_ready_o;
    logic          cmp_valid_o;
    logic [511:0]  cmp_h_o;
    logic [1023:0] cmp_m_o;
    logic [127:0]  cmp_t_o;
    logic          cmp_f_o;
    logic [511:0]  cmp_h_i;
    logic          cmp_valid_i;
    logic          digest_valid_o;
    logic [511:0]  digest_o;
    logic          digest_ready_i;

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;
    int eng_delay = 12;
    int spur_cnt = 0;
    logic spur_req = 1'b0;
    logic [511:0] model_h;
    logic [7:0] msg [256];
    blk_t sbq [$];
    blk_t ee;

    always #5 clk = ~clk;

    blake2b_msg_sched #(.W(64), .NN(NN)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .data_last_i    (data_last_i),
        .data_bytes_i   (data_bytes_i),
        .data_ready_o   (data_ready_o),
        .cmp_valid_o    (cmp_valid_o),
        .cmp_h_o        (cmp_h_o),
        .cmp_m_o        (cmp_m_o),
        .cmp_t_o        (cmp_t_o),
        .cmp_f_o        (cmp_f_o),
        .cmp_h_i        (cmp_h_i),
        .cmp_valid_i    (cmp_valid_i),
        .digest_valid_o (digest_valid_o),
        .digest_o       (digest_o),
        .digest_ready_i (digest_ready_i)
    );

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [3:0] sig(input int r, input int j);
        logic [63:0] row;
        case (r)
            0: row = 64'h0123456789abcdef;
            1: row = 64'hea489fd61c02b753;
            2: row = 64'hb8c052fdae367194;
            3: row = 64'h7931dcbe265a40f8;
            4: row = 64'h905724afe1bc683d;
            5: row = 64'h2c6a0b834d75fe19;
            6: row = 64'hc51fed4a0763928b;
            7: row = 64'hdb7ec13950f4862a;
            8: row = 64'h6fe9b308cd1a2574;
            default: row = 64'ha2847615fb9e3cd0;
        endcase
        return row[60-4*j +: 4];
    endfunction

    function automatic logic [511:0] compress(input logic [511:0] h,
        input logic [1023:0] m, input logic [127:0] t, input logic f);
        logic [63:0] v [16];
        logic [63:0] mw [16];
        logic [63:0] x, y;
        logic [511:0] res;
        int a, b, c, d, k;
        for (int i = 0; i < 8; i++) begin
            v[i]   = h[64*i +: 64];
            v[i+8] = BIV[64*i +: 64];
        end
        for (int i = 0; i < 16; i++) mw[i] = m[64*i +: 64];
        v[12] = v[12] ^ t[63:0];
        v[13] = v[13] ^ t[127:64];
        if (f) v[14] = ~v[14];
        for (int r = 0; r < 12; r++) begin
            for (int g = 0; g < 8; g++) begin
                if (g < 4) begin
                    a = g; b = g + 4; c = g + 8; d = g + 12;
                end else begin
                    k = g - 4;
                    a = k; b = 4 + (k + 1) % 4;
                    c = 8 + (k + 2) % 4; d = 12 + (k + 3) % 4;
                end
                x = mw[sig(r % 10, 2*g)];
                y = mw[sig(r % 10, 2*g + 1)];
                v[a] = v[a] + v[b] + x;
                v[d] = rotr(v[d] ^ v[a], 32);
                v[c] = v[c] + v[d];
                v[b] = rotr(v[b] ^ v[c], 24);
                v[a] = v[a] + v[b] + y;
                v[d] = rotr(v[d] ^ v[a], 16);
                v[c] = v[c] + v[d];
                v[b] = rotr(v[b] ^ v[c], 63);
            end
        end
        for (int i = 0; i < 8; i++)
            res[64*i +: 64] = h[64*i +: 64] ^ v[i] ^ v[i+8];
        return res;
    endfunction

    function automatic logic [511:0] dmask(input logic [511:0] h);
        logic [511:0] r;
        r = '0;
        for (int b = 0; b < 64; b++)
            if (b < NN) r[8*b +: 8] = h[8*b +: 8];
        return r;
    endfunction

    // Engine model: answers each pulse after eng_delay cycles.
    initial begin
        logic [511:0] h_in;
        logic ok, aborted;
        cmp_valid_i = 1'b0;
        cmp_h_i = '0;
        forever begin
            @(negedge clk);
            if (spur_req && spur_cnt == 0) begin
                cmp_valid_i = 1'b1;
                cmp_h_i = {16{32'hdeadbeef}};
                @(negedge clk);
                cmp_valid_i = 1'b0;
                spur_cnt++;
            end else if (nreset && cmp_valid_o) begin
                check("pulse_expected", 512'(sbq.size() != 0), 512'd1);
                if (sbq.size() != 0) begin
                    ee = sbq.pop_front();
                    n_pulse++;
                    check("blk_t", cmp_t_o, 512'(ee.t));
                    check("blk_f", cmp_f_o, 512'(ee.f));
                    check("blk_m_lo", cmp_m_o[511:0], ee.m[511:0]);
                    check("blk_m_hi", cmp_m_o[1023:512], ee.m[1023:512]);
                    check("blk_h", cmp_h_o, model_h);
                    h_in = model_h;
                    model_h = compress(model_h, ee.m, ee.t, ee.f);
                    ok = 1'b1;
                    aborted = 1'b0;
                    for (int c = 0; c < eng_delay && !aborted; c++) begin
                        @(negedge clk);
                        if (!nreset) aborted = 1'b1;
                        else if (!(cmp_valid_o === 1'b0 && cmp_t_o === ee.t &&
                                   cmp_f_o === ee.f && cmp_m_o === ee.m &&
                                   cmp_h_o === h_in && data_ready_o === 1'b0))
                            ok = 1'b0;
                    end
                    check("blk_hold", 512'(ok), 512'd1);
                    if (!aborted) begin
                        cmp_valid_i = 1'b1;
                        cmp_h_i = model_h;
                        @(negedge clk);
                        cmp_valid_i = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_msg(input int n);
        blk_t e;
        int nw, nb, wib, cnt;
        logic last;
        logic [63:0] w, junk;
        nw = (n == 0) ? 1 : (n + 7) / 8;
        e.t = '0;
        e.f = 1'b0;
        e.m = '0;
        wib = 0;
        for (int k = 0; k < nw; k++) begin
            last = (k == nw - 1);
            nb = last ? n - 8 * k : 8;
            w = '0;
            junk = 64'ha5c3_5a3c_e1f0_0f1e;
            for (int b = 0; b < nb; b++) begin
                w[8*b +: 8] = msg[8*k + b];
                junk[8*b +: 8] = 8'h00;
            end
            e.m[64*wib +: 64] = w;
            e.t = e.t + 128'(nb);
            wib++;
            if (last || wib == 16) begin
                e.f = last;
                sbq.push_back(e);
            end
            data_valid_i = 1'b1;
            data_i = w | junk;
            data_last_i = last;
            data_bytes_i = last ? 4'(nb) : 4'd3;
            cnt = 0;
            while (!data_ready_o && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            check("ready_wait", 512'(data_ready_o), 512'd1);
            @(posedge clk);
            @(negedge clk);
            if (last || wib == 16) begin
                check("pulse_lat", 512'(cmp_valid_o), 512'd1);
                wib = 0;
                e.m = '0;
            end
        end
        data_valid_i = 1'b0;
        data_last_i = 1'b0;
        data_bytes_i = 4'd0;
    endtask

    task automatic get_digest(input int hold, output logic [511:0] d);
        int cnt;
        logic ok;
        cnt = 0;
        while (!digest_valid_o && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        check("digest_valid", 512'(digest_valid_o), 512'd1);
        d = digest_o;
        check("digest", digest_o, dmask(model_h));
        check("dig_busy", 512'(data_ready_o), 512'd0);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(digest_valid_o === 1'b1 && digest_o === d &&
                  data_ready_o === 1'b0))
                ok = 1'b0;
        end
        if (hold > 0) check("dig_hold", 512'(ok), 512'd1);
        digest_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        digest_ready_i = 1'b0;
        check("post_rdy", 512'(data_ready_o), 512'd1);
        check("post_dv", 512'(digest_valid_o), 512'd0);
        check("post_h", cmp_h_o, BINIT);
        check("post_t", cmp_t_o, 512'd0);
        check("sb_empty", 512'(sbq.size()), 512'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        int p0;
        logic ok;
        nreset = 1'b0;
        data_valid_i = 1'b0;
        data_i = '0;
        data_last_i = 1'b0;
        data_bytes_i = 4'd0;
        digest_ready_i = 1'b0;
        model_h = BINIT;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("rst_ready", 512'(data_ready_o), 512'd1);
        check("rst_cv", 512'(cmp_valid_o), 512'd0);
        check("rst_dv", 512'(digest_valid_o), 512'd0);
        check("rst_h", cmp_h_o, BINIT);
        check("rst_m", cmp_m_o[511:0] | cmp_m_o[1023:512], 512'd0);
        check("rst_t", cmp_t_o, 512'd0);
        check("rst_f", 512'(cmp_f_o), 512'd0);

        // Empty message.
        model_h = BINIT;
        p0 = n_pulse;
        send_msg(0);
        get_digest(0, d);
        check("empty_d0", d[63:0], 512'h03590142f7026a78);
        check("empty_np", 512'(n_pulse - p0), 512'd1);

        // "abc".
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        model_h = BINIT;
        send_msg(3);
        get_digest(0, d);
        check("abc_d0", d[63:0], 512'h0d4d1c983fa580ba);

        // Stray engine done while idle must be ignored.
        spur_req = 1'b1;
        for (int i = 0; i < 10 && spur_cnt == 0; i++) @(negedge clk);
        spur_req = 1'b0;
        @(negedge clk);
        check("spur_h", cmp_h_o, BINIT);
        check("spur_rdy", 512'(data_ready_o), 512'd1);

        // Exactly one full block, with a long digest hold.
        for (int i = 0; i < 256; i++) msg[i] = 8'(i);
        model_h = BINIT;
        p0 = n_pulse;
        send_msg(128);
        get_digest(20, d);
        check("b128_np", 512'(n_pulse - p0), 512'd1);

        // One byte over a block, with a slow engine.
        eng_delay = 17;
        model_h = BINIT;
        p0 = n_pulse;
        send_msg(129);
        get_digest(0, d);
        check("b129_np", 512'(n_pulse - p0), 512'd2);
        eng_delay = 12;

        // Reset during compression aborts the message.
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        model_h = BINIT;
        send_msg(3);
        repeat (5) @(negedge clk);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        check("ab_ready", 512'(data_ready_o), 512'd1);
        check("ab_h", cmp_h_o, BINIT);
        nreset = 1'b1;
        @(negedge clk);
        check("ab_t", cmp_t_o, 512'd0);
        check("ab_m", cmp_m_o[511:0] | cmp_m_o[1023:512], 512'd0);
        check("ab_f", 512'(cmp_f_o), 512'd0);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digest_valid_o !== 1'b0 || cmp_valid_o !== 1'b0 ||
                data_ready_o !== 1'b1)
                ok = 1'b0;
        end
        check("ab_quiet", 512'(ok), 512'd1);
        model_h = BINIT;
        send_msg(3);
        get_digest(0, d);
        check("ab_abc_d0", d[63:0], 512'h0d4d1c983fa580ba);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
